// File: rtl/da2dac.sv
// da2dac: dual-channel serial transmitter for a two-channel 12-bit DAC.
// Accepts two samples plus a power-down command over a four-phase
// dacdav/davdac handshake, then shifts both 16-bit words out MSB first
// on a shared SYNC/SCLK pair. Data changes on SCLK rising edges and the
// DAC samples on falling edges.
module da2dac #(
  parameter int unsigned HALF = 1,
  parameter int unsigned GAP  = 2
) (
  input  logic        dacclk,
  input  logic        reset,
  input  logic        dacdav,
  output logic        davdac,
  input  logic [11:0] dac0data,
  input  logic [11:0] dac1data,
  input  logic [1:0]  daccmd,
  output logic        dacsck,
  output logic        daccs,
  output logic        dac0d,
  output logic        dac1d,
  output logic        busy
);

  localparam int unsigned DIV_W = $clog2(HALF) + 1;
  localparam int unsigned GAP_W = $clog2(GAP) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP,
    ST_DONE
  } state_t;

  state_t           state;
  logic [15:0]      sr0;
  logic [15:0]      sr1;
  logic [3:0]       bit_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [15:0]      word0;
  logic [15:0]      word1;

  // Frame words: two zero pad bits, power-down command, 12-bit sample.
  assign word0 = {2'b00, daccmd, dac0data};
  assign word1 = {2'b00, daccmd, dac1data};

  // Handshake, SCLK divider, bit sequencing and SYNC framing.
  always_ff @(posedge dacclk) begin
    if (reset) begin
      state   <= ST_IDLE;
      davdac  <= 1'b0;
      busy    <= 1'b0;
      daccs   <= 1'b1;
      dacsck  <= 1'b1;
      dac0d   <= 1'b0;
      dac1d   <= 1'b0;
      sr0     <= '0;
      sr1     <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          dacsck <= 1'b1;
          daccs  <= 1'b1;
          if (dacdav) begin
            // Bit 15 goes straight to the pins; the rest wait in the top of sr.
            dac0d   <= word0[15];
            dac1d   <= word1[15];
            sr0     <= {word0[14:0], 1'b0};
            sr1     <= {word1[14:0], 1'b0};
            davdac  <= 1'b1;
            busy    <= 1'b1;
            daccs   <= 1'b0;
            bit_cnt <= '0;
            div_cnt <= '0;
            state   <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (dacsck) begin
              dacsck <= 1'b0;
            end else if (bit_cnt == 4'd15) begin
              // Rising edge after the 16th falling edge closes the frame.
              dacsck  <= 1'b1;
              daccs   <= 1'b1;
              dac0d   <= 1'b0;
              dac1d   <= 1'b0;
              gap_cnt <= '0;
              state   <= ST_GAP;
            end else begin
              dacsck  <= 1'b1;
              bit_cnt <= bit_cnt + 4'd1;
              dac0d   <= sr0[15];
              dac1d   <= sr1[15];
              sr0     <= {sr0[14:0], 1'b0};
              sr1     <= {sr1[14:0], 1'b0};
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= ST_DONE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        ST_DONE: begin
          if (!dacdav) begin
            davdac <= 1'b0;
            busy   <= 1'b0;
            state  <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_da2dac.sv
// Bench for da2dac: a driver issues requests and queues the expected
// frame words; a monitor decodes SYNC/SCLK/DIN at the pins and compares.
// Two instances cover the default timing and HALF=3/GAP=4.
module tb_da2dac;

  typedef struct packed {
    logic [15:0] w0;
    logic [15:0] w1;
  } frame_t;

  logic        clk;
  logic        rst;
  logic        dav;
  logic        act;
  logic [11:0] d0data;
  logic [11:0] d1data;
  logic [1:0]  cmd;

  logic dav0, dav1;
  logic davdac0, sck0, cs0, o00, o10, busy0;
  logic davdac1, sck1, cs1, o01, o11, busy1;
  logic m_davdac, m_sck, m_cs, m_d0, m_d1, m_busy;

  assign dav0 = dav & ~act;
  assign dav1 = dav & act;
  assign m_davdac = act ? davdac1 : davdac0;
  assign m_sck    = act ? sck1    : sck0;
  assign m_cs     = act ? cs1     : cs0;
  assign m_d0     = act ? o01     : o00;
  assign m_d1     = act ? o11     : o10;
  assign m_busy   = act ? busy1   : busy0;

  da2dac u_dut0 (
    .dacclk(clk), .reset(rst), .dacdav(dav0), .davdac(davdac0),
    .dac0data(d0data), .dac1data(d1data), .daccmd(cmd),
    .dacsck(sck0), .daccs(cs0), .dac0d(o00), .dac1d(o10), .busy(busy0)
  );

  da2dac #(.HALF(3), .GAP(4)) u_dut1 (
    .dacclk(clk), .reset(rst), .dacdav(dav1), .davdac(davdac1),
    .dac0data(d0data), .dac1data(d1data), .daccmd(cmd),
    .dacsck(sck1), .daccs(cs1), .dac0d(o01), .dac1d(o11), .busy(busy1)
  );

  always #5 clk = ~clk;

  int     n_checks;
  int     n_fail;
  frame_t exp_q[$];

  // Monitor state
  logic        pcs, psck, pd0, pd1;
  logic        started, skip_gap, abort;
  logic [15:0] cap0, cap1;
  int          falls, low_run, seg, bad_half, glitch, gap_run, frames;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  // Pin-level decoder: captures bits on SCLK falling edges while SYNC is low.
  always @(negedge clk) begin
    int     cur_half;
    int     cur_gap;
    frame_t e;
    cur_half = act ? 3 : 1;
    cur_gap  = act ? 4 : 2;
    if (pcs && !m_cs) begin
      if (started && !skip_gap) chk("sync_gap_ge_gap", 32'(gap_run >= cur_gap), 32'd1);
      skip_gap = 1'b0;
      started  = 1'b1;
      cap0 = '0; cap1 = '0;
      falls = 0; low_run = 0; bad_half = 0; glitch = 0;
    end
    if (!m_cs) begin
      low_run++;
      if (!pcs) begin
        if (m_sck != psck) begin
          if (seg != cur_half) bad_half++;
          seg = 1;
        end else begin
          seg++;
        end
        if ((m_d0 != pd0 || m_d1 != pd1) && !(!psck && m_sck)) glitch++;
        if (psck && !m_sck) begin
          cap0 = {cap0[14:0], m_d0};
          cap1 = {cap1[14:0], m_d1};
          falls++;
        end
      end else begin
        seg = 1;
      end
    end else if (!pcs) begin
      if (seg != cur_half) bad_half++;
      if (abort) begin
        abort    = 1'b0;
        skip_gap = 1'b1;
        chk("aborted_frame_short", 32'(falls < 16), 32'd1);
        if (exp_q.size() > 0) e = exp_q.pop_front();
      end else if (exp_q.size() == 0) begin
        chk("unexpected_frame", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("word_ch0", 32'(cap0), 32'(e.w0));
        chk("word_ch1", 32'(cap1), 32'(e.w1));
        chk("sync_low_cycles", 32'(low_run), 32'(32 * cur_half));
        chk("falling_edges", 32'(falls), 32'd16);
        chk("sck_half_period_errs", 32'(bad_half), 32'd0);
        chk("data_change_off_rise", 32'(glitch), 32'd0);
        chk("din_idle_zero", {30'd0, m_d0, m_d1}, 32'd0);
        frames++;
      end
      gap_run = 1;
    end else begin
      gap_run++;
    end
    pcs  = m_cs;
    psck = m_sck;
    pd0  = m_d0;
    pd1  = m_d1;
  end

  // One handshake: raise dacdav, hold it, drop it, wait for davdac to fall.
  task automatic req(input logic [11:0] a, input logic [11:0] b, input logic [1:0] c,
                     input int hold, input int chg_at, input bit prompt_drop);
    int f0, n, hold_bad;
    bit changed;
    frame_t e;
    f0 = frames;
    hold_bad = 0;
    changed = 0;
    d0data = a; d1data = b; cmd = c;
    e.w0 = {2'b00, c, a};
    e.w1 = {2'b00, c, b};
    exp_q.push_back(e);
    dav = 1'b1;
    @(negedge clk);
    chk("ack_after_req", {29'd0, m_davdac, m_busy, m_cs}, 32'b110);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!m_davdac) hold_bad++;
      if (chg_at > 0 && !changed && falls >= chg_at) begin
        d0data = 12'hFFF;
        changed = 1;
      end
    end
    if (prompt_drop) chk("ack_held_while_dav", 32'(hold_bad), 32'd0);
    dav = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_davdac && n < 400);
    chk("ack_drop_timeout", 32'(m_davdac), 32'd0);
    if (prompt_drop) chk("ack_drop_latency", 32'(n), 32'd1);
    chk("busy_low_after_ack", 32'(m_busy), 32'd0);
    chk("one_frame_per_req", 32'(frames - f0), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    clk = 1'b0; rst = 1'b1; dav = 1'b0; act = 1'b0;
    d0data = '0; d1data = '0; cmd = '0;
    n_checks = 0; n_fail = 0; frames = 0;
    pcs = 1'b1; psck = 1'b1; pd0 = 1'b0; pd1 = 1'b0;
    started = 1'b0; skip_gap = 1'b0; abort = 1'b0;
    cap0 = '0; cap1 = '0;
    falls = 0; low_run = 0; seg = 0; bad_half = 0; glitch = 0; gap_run = 0;

    repeat (3) @(negedge clk);
    chk("reset_outputs", {26'd0, m_davdac, m_busy, m_cs, m_sck, m_d0, m_d1}, 32'b001100);
    rst = 1'b0;
    @(negedge clk);

    // Directed frames
    req(12'hA5C, 12'h3FF, 2'b00, 3,   0, 1'b0);
    req(12'h000, 12'hFFF, 2'b11, 2,   0, 1'b0);
    req(12'h155, 12'h2AA, 2'b01, 100, 0, 1'b1);
    req(12'h0F0, 12'h00F, 2'b10, 0,   0, 1'b0);
    req(12'h123, 12'h456, 2'b00, 40,  5, 1'b0);

    // Reset mid-frame, then a fresh request
    begin
      frame_t e;
      d0data = 12'h5A5; d1data = 12'hA5A; cmd = 2'b00;
      e.w0 = {4'h0, 12'h5A5};
      e.w1 = {4'h0, 12'hA5A};
      exp_q.push_back(e);
      dav = 1'b1;
      repeat (2) @(negedge clk);
      n = 0;
      while (falls < 8 && n < 400) begin
        @(negedge clk);
        n++;
      end
      chk("reach_8th_fall", 32'(falls >= 8), 32'd1);
      abort = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      chk("mid_frame_reset", {28'd0, m_davdac, m_busy, m_cs, m_sck}, 32'b0011);
      rst = 1'b0;
      dav = 1'b0;
      @(negedge clk);
    end
    req(12'hC3C, 12'h3C3, 2'b00, 1, 0, 1'b0);

    // Random requests on default timing
    for (int i = 0; i < 8; i++) begin
      req(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
          2'($urandom_range(0, 3)), int'($urandom_range(0, 60)), 0, 1'b0);
    end

    // Slow timing instance
    act = 1'b1;
    repeat (2) @(negedge clk);
    req(12'h800, 12'h001, 2'b00, 5, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      req(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
          2'($urandom_range(0, 3)), int'($urandom_range(0, 150)), 0, 1'b0);
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/da2dac.md
Name: da2dac

Overview:
- Dual-channel serial transmitter for the two-channel 12-bit DAC module (PmodDA2, 2x DAC121S101).
- Output-side counterpart of the ADC receiver. It accepts two 12-bit samples plus a 2-bit power-down command from the signal generator/filter over the dacdav/davdac four-phase handshake.
- It shifts both samples out simultaneously, MSB first, on a shared SYNC/SCLK pair.
- It sits between the processing core and the DAC pins, clocked by the 25 MHz system clock.

Parameters:
- HALF, 1: dacclk cycles per SCLK half-period (>=1). Default gives SCLK = 12.5 MHz at 25 MHz.
- GAP, 2: dacclk cycles daccs is held high after each frame before the handshake can complete (>=1).

Ports:
- dacclk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- dacdav  in  1  producer request; data/cmd valid and stable while high.
- davdac  out  1  acknowledge; words latched and frame in progress or complete.
- dac0data  in  12  channel A sample, unsigned straight binary.
- dac1data  in  12  channel B sample.
- daccmd  in  2  DAC power-down bits PD1:PD0 (00 = normal operation), shared by both channels.
- dacsck  out  1  serial clock to DAC, idle high.
- daccs  out  1  SYNC, active low, frames one 16-bit word.
- dac0d  out  1  serial data, channel A (DINA).
- dac1d  out  1  serial data, channel B (DINB).
- busy  out  1  high from latch until return to IDLE.

Behaviour:
- Reset values (on the next edge with reset=1, regardless of state, including mid-frame): davdac=0, daccs=1, dacsck=1, dac0d=0, dac1d=0, busy=0. Shift registers, bit counter and divider counter are cleared; state is IDLE. An aborted frame is not resumed.
- Frame word per channel: {2'b00, daccmd, dacNdata}, 16 bits, bit 15 first.
- States: IDLE -> SHIFT -> GAP -> DONE -> IDLE.
- IDLE:
  - dacsck=1, daccs=1.
  - On a cycle with dacdav=1, both 16-bit words are latched.
  - On the next cycle: davdac=1, busy=1, daccs=0, and dac0d/dac1d = bit 15. The divider and bit counter are cleared. Go to SHIFT.
- SHIFT:
  - A divider counts HALF cycles; dacsck toggles at each terminal count.
  - The DAC samples on the falling edge. Data updates to the next bit coincident with each rising edge, so data is stable a full half-period around each falling edge.
  - Taking the cycle daccs falls as t=0: falling edge k (k=0..15) occurs at t=(2k+1)·HALF, and data bit (15-k) is valid over [2k·HALF, (2k+2)·HALF).
  - After the 16th falling edge, at t=32·HALF: dacsck=1, daccs=1, dac0d=dac1d=0. Go to GAP.
  - Exactly 16 falling edges per frame.
- GAP: hold daccs=1 for GAP cycles, then go to DONE.
- DONE:
  - If dacdav=0: davdac=0 and busy=0 on the next cycle; go to IDLE.
  - Otherwise wait in DONE.
  - A new request is recognised only in IDLE with dacdav=1, so each dacdav high pulse produces exactly one frame.
- Inputs dac0data/dac1data/daccmd are sampled only at the latch. Changes during SHIFT/GAP/DONE have no effect on the frame in progress.
- dacdav dropping early (during SHIFT) does not abort the frame. davdac stays high until DONE sees dacdav=0.
- Minimum request-to-request period: 1 + 32·HALF + GAP + 1 + 1 cycles (37 at defaults) when the producer drops dacdav promptly.
- Bit counter is 4 bits and the divider is sized to ceil(log2(HALF))+1. No wrap-around beyond 16 bits is permitted; the counter terminates at 15.

Test Plan:
- Defaults; dac0data=0xA5C, dac1data=0x3FF, daccmd=00, one dacdav pulse. Required: daccs low for exactly 32 cycles; 16 falling dacsck edges; bits captured on falling edges are dac0d=0x0A5C, dac1d=0x03FF; davdac rises 1 cycle after the request; busy drops after dacdav is low.
- daccmd=11, data 0x000/0xFFF. Required: captured words 0x3000 and 0x3FFF.
- dacdav held high for 100 cycles. Required: exactly one frame and davdac high throughout. After dacdav falls, davdac=0 one cycle later, and the next dacdav pulse starts a second frame with no SYNC gap shorter than GAP.
- dac0data changed from 0x123 to 0xFFF at the 5th falling edge. Required: captured word is still 0x0123.
- reset asserted at the 8th falling edge. Required: next cycle daccs=1, dacsck=1, davdac=0, busy=0. A fresh request afterwards sends a complete, correct 16-bit frame.
- HALF=3, GAP=4, data 0x800/0x001. Required: dacsck half-period of 3 cycles, daccs low for 96 cycles then high at least 4 cycles, captured words 0x0800 and 0x0001.
